// File: rtl/ram_dma_master.sv
// Single-channel RAM initiator: ascending block copy (read/write pairs) or block fill.
// Memory-side outputs are decoded purely from the registered state so the port mux sees clean timing.
module ram_dma_master #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          mode_i,
  input  logic [AW-1:0] src_addr_i,
  input  logic [AW-1:0] dst_addr_i,
  input  logic [LW-1:0] len_i,
  input  logic [DW-1:0] fill_data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [LW-1:0] count_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_data_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  logic [1:0]    state_reg;
  logic          mode_reg;
  logic [AW-1:0] src_reg;
  logic [AW-1:0] dst_reg;
  logic [LW-1:0] rem_reg;
  logic [DW-1:0] data_reg;
  logic [LW-1:0] count_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_IDLE;
      mode_reg  <= 1'b0;
      src_reg   <= '0;
      dst_reg   <= '0;
      rem_reg   <= '0;
      data_reg  <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // abort has priority over a simultaneous start
          if (start_i && !abort_i) begin
            mode_reg  <= mode_i;
            src_reg   <= src_addr_i;
            dst_reg   <= dst_addr_i;
            rem_reg   <= len_i;
            data_reg  <= fill_data_i;
            count_reg <= '0;
            if (len_i == '0)  state_reg <= S_DONE;
            else if (mode_i)  state_reg <= S_WRITE;
            else              state_reg <= S_READ;
          end
        end
        S_READ: begin
          if (abort_i) begin
            state_reg <= S_IDLE;
          end else begin
            data_reg  <= mem_data_i;
            src_reg   <= src_reg + STEP;
            state_reg <= S_WRITE;
          end
        end
        S_WRITE: begin
          // the write strobed this cycle lands even when aborting, so it is counted
          dst_reg   <= dst_reg + STEP;
          rem_reg   <= rem_reg - LW'(1);
          count_reg <= count_reg + LW'(1);
          if (abort_i)                 state_reg <= S_IDLE;
          else if (rem_reg == LW'(1))  state_reg <= S_DONE;
          else if (mode_reg)           state_reg <= S_WRITE;
          else                         state_reg <= S_READ;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy_o     = (state_reg != S_IDLE);
    done_o     = (state_reg == S_DONE);
    count_o    = count_reg;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (state_reg == S_READ) begin
      mem_addr_o = src_reg;
    end else if (state_reg == S_WRITE) begin
      mem_we_o   = 1'b1;
      mem_addr_o = dst_reg;
      mem_data_o = data_reg;
    end
  end

endmodule

// File: tb/tb_ram_dma_master.sv
// Bench for ram_dma_master: table of transfers (directed + random) checked against a
// sequential copy/fill model over a 4 KB mirrored RAM, plus reset and abort sequences.
module tb_ram_dma_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, mode;
  logic [31:0] src, dst, fill;
  logic [15:0] len;
  logic        busy, done, we;
  logic [15:0] count;
  logic [31:0] maddr, mdo, mdi;

  logic [31:0] ram [0:1023];
  assign mdi = ram[maddr[11:2]];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_dma_master #(.AW(32), .DW(32), .LW(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .mode_i(mode),
    .src_addr_i(src), .dst_addr_i(dst), .len_i(len), .fill_data_i(fill),
    .busy_o(busy), .done_o(done), .count_o(count), .mem_we_o(we),
    .mem_addr_o(maddr), .mem_data_o(mdo), .mem_data_i(mdi)
  );

  typedef struct {
    logic        mode;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] fill;
    logic [15:0] len;
    int          exp_writes;
    int          exp_done;
  } vec_t;

  localparam int NDIR = 5;
  localparam int NRND = 20;
  vec_t vecs [0:NDIR+NRND-1];

  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  int          exp_cyc  [$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: words are moved one at a time in ascending order, so overlapping copies propagate.
  task automatic build_model(input vec_t v);
    logic [31:0] snap [0:1023];
    logic [31:0] a_s, a_d, d;
    snap = ram;
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      a_s = v.src + 32'(4 * i);
      a_d = v.dst + 32'(4 * i);
      d   = v.mode ? v.fill : snap[a_s[11:2]];
      snap[a_d[11:2]] = d;
      exp_addr.push_back(a_d);
      exp_data.push_back(d);
      exp_cyc.push_back(v.mode ? i : 2 * i + 1);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  n_writes = 0;
    int  done_cyc = -1;
    bit  done_seen = 0;
    int  budget;
    build_model(v);
    @(negedge clk);
    mode = v.mode; src = v.src; dst = v.dst; fill = v.fill; len = v.len; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    budget = 2 * int'(v.len) + 4;
    for (int c = 0; c < budget && !done_seen; c++) begin
      @(negedge clk);
      check($sformatf("busy[%0d] c=%0d", idx, c), 96'(busy), 96'(1));
      if (we) begin
        if (n_writes < exp_addr.size())
          check($sformatf("write[%0d] n=%0d addr/data/cycle", idx, n_writes),
                {maddr, mdo, 32'(c)},
                {exp_addr[n_writes], exp_data[n_writes], 32'(exp_cyc[n_writes])});
        ram[maddr[11:2]] = mdo;
        n_writes++;
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = c;
        start     = 1'b0;
      end else begin
        // scribble on config and pulse start while busy: all must be ignored
        start = 1'($urandom_range(0, 1));
        mode = 1'($urandom); len = 16'($urandom); src = $urandom; dst = $urandom; fill = $urandom;
      end
    end
    check($sformatf("done_cycle[%0d]", idx), 96'(32'(done_cyc)), 96'(32'(v.exp_done)));
    check($sformatf("write_count[%0d]", idx), 96'(n_writes), 96'(v.exp_writes));
    @(negedge clk);
    check($sformatf("idle_after[%0d] done/busy/we/count", idx),
          {93'(count), done, busy, we}, {93'(v.len), 3'b000});
    $display("xfer %0d mode=%0d src=%h dst=%h len=%0d writes=%0d done_cycle=%0d",
             idx, v.mode, v.src, v.dst, v.len, n_writes, done_cyc);
  endtask

  initial begin
    int n;
    int lat;
    bit saw_done;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h5A000000 | 32'(i * 7);
    ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;

    vecs[0] = '{1'b0, 32'h00,  32'h40,       32'h0,        16'd4, 4, 8};
    vecs[1] = '{1'b1, 32'h00,  32'h100,      32'hDEADBEEF, 16'd3, 3, 3};
    vecs[2] = '{1'b0, 32'h10,  32'h140,      32'h0,        16'd0, 0, 0};
    vecs[3] = '{1'b0, 32'h20,  32'hFFFFFFFC, 32'h0,        16'd2, 2, 4};
    vecs[4] = '{1'b0, 32'h200, 32'h204,      32'h0,        16'd3, 3, 6};
    for (int i = NDIR; i < NDIR + NRND; i++) begin
      vecs[i].mode = 1'($urandom);
      vecs[i].src  = $urandom & 32'hFFFFFFFC;
      vecs[i].dst  = $urandom & 32'hFFFFFFFC;
      vecs[i].fill = $urandom;
      vecs[i].len  = 16'($urandom_range(0, 12));
      vecs[i].exp_writes = int'(vecs[i].len);
      vecs[i].exp_done   = vecs[i].mode ? int'(vecs[i].len) : 2 * int'(vecs[i].len);
    end

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    src = '0; dst = '0; fill = '0; len = '0;
    #3;
    check("reset_outputs", {maddr, mdo, 16'(count), 13'(0), busy, done, we}, 96'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {maddr, mdo, 16'(count), 13'(0), busy, done, we}, 96'(0));

    for (int i = 0; i < NDIR + NRND; i++) run_vec(vecs[i], i);

    // Async reset in the middle of a copy of 8 words.
    @(negedge clk);
    mode = 1'b0; src = 32'h0; dst = 32'h300; len = 16'd8; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(negedge clk);
    check("midcopy_busy", 96'(busy), 96'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midcopy_reset_outputs", {maddr, mdo, 16'(count), 13'(0), busy, done, we}, 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (we || busy) n++;
    end
    check("after_reset_quiet", 96'(n), 96'(0));
    $display("reset mid-copy: activity cycles after reset=%0d", n);

    // Abort on the 4th write of a 10-word fill.
    @(negedge clk);
    mode = 1'b1; dst = 32'h380; fill = 32'hA5A5A5A5; len = 16'd10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0; saw_done = 0;
    for (int c = 0; c < 20 && abort == 1'b0; c++) begin
      @(negedge clk);
      if (we) n++;
      if (done) saw_done = 1;
      if (n == 4) abort = 1'b1;
    end
    @(posedge clk); #1; abort = 1'b0;
    check("abort_busy_next", {94'(0), busy, done}, 96'(0));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (we) n++;
      if (done) saw_done = 1;
    end
    check("abort_writes", 96'(n), 96'(4));
    check("abort_no_done", 96'(saw_done), 96'(0));
    $display("abort: writes=%0d done_seen=%0d", n, saw_done);

    // Abort beats start in IDLE.
    @(negedge clk);
    mode = 1'b1; dst = 32'h3C0; len = 16'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    check("abort_over_start", {94'(0), busy, we}, 96'(0));
    lat = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy) lat++;
    end
    check("abort_over_start_quiet", 96'(lat), 96'(0));
    $display("abort+start in idle: busy cycles=%0d", lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dma_master.md
Name: ram_dma_master

Overview:
- Single-channel memory initiator that drives the word-addressed single-port RAM interface (write enable, byte address, write data, combinational read data).
- Performs block copy (read src word, write dst word) or block fill (write constant) of len_i words.
- Sits beside the core as a second RAM master behind a top-level mux; busy_o grants it the port.

Parameters:
- AW, 32, byte-address width of the RAM port.
- DW, 32, data word width; addresses step by DW/8 bytes.
- LW, 16, width of the word-count (length) field.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  launch request, sampled only in IDLE
- abort_i  input  1  synchronous abort, returns to IDLE without done_o
- mode_i  input  1  0 = copy, 1 = fill; latched at start
- src_addr_i  input  AW  copy source byte address (word aligned), latched at start
- dst_addr_i  input  AW  destination byte address (word aligned), latched at start
- len_i  input  LW  number of words, latched at start
- fill_data_i  input  DW  fill pattern, latched at start
- busy_o  output  1  high in any state other than IDLE
- done_o  output  1  one-cycle completion pulse
- count_o  output  LW  words written so far in current/last transfer
- mem_we_o  output  1  RAM write enable (active high)
- mem_addr_o  output  AW  RAM byte address
- mem_data_o  output  DW  RAM write data
- mem_data_i  input  DW  RAM read data, valid combinationally in the same cycle as mem_addr_o

Behaviour:
- Reset (async, rst_ni=0): state IDLE; busy_o=0, done_o=0, count_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0; internal src/dst/remaining/data registers cleared. Reset mid-transfer aborts immediately; no further writes.
- States: IDLE, READ, WRITE, DONE. Memory outputs decoded from registered state only.
- IDLE: outputs as reset values (count_o holds last value). On start_i=1: latch mode/src/dst/len/fill, count_o<=0; if len_i==0 -> DONE; else copy -> READ, fill -> WRITE (data reg <= fill_data_i).
- READ: mem_we_o=0, mem_addr_o=src reg. At edge: data reg <= mem_data_i, src += DW/8, -> WRITE.
- WRITE: mem_we_o=1, mem_addr_o=dst reg, mem_data_o=data reg. At edge: dst += DW/8, remaining -= 1, count_o += 1; if remaining==1 -> DONE, else copy -> READ, fill -> stay WRITE.
- DONE: done_o=1 for exactly one cycle, busy_o=1, mem_we_o=0; -> IDLE.
- Latency from start edge to done_o high: copy 2*len cycles, fill len cycles, len=0 one cycle (done in cycle after start).
- start_i ignored while busy_o=1; changes to config inputs after start have no effect.
- abort_i=1 in READ/WRITE/DONE: -> IDLE at next edge, no done_o; a WRITE cycle in progress still completes its write (mem_we_o already asserted that cycle). abort_i wins over start_i in IDLE (start ignored).
- Address arithmetic modulo 2^AW (wraps at top of space); low log2(DW/8) address bits passed through unchanged, never checked.
- Copy is strictly ascending; overlapping regions with dst > src produce propagated data (defined, not corrected).

Test Plan:
- Reset then idle: rst_ni low mid-copy of len=8 -> all outputs 0 immediately, no writes after reset edge, busy_o=0.
- Copy: RAM[0x00..0x0C]=0x11,0x22,0x33,0x44; start copy src=0x00 dst=0x40 len=4 -> four writes 0x40..0x4C with same data, alternating READ/WRITE, done_o pulse 8 cycles after start, count_o=4.
- Fill: mode=1 dst=0x100 len=3 fill=0xDEADBEEF -> mem_we_o high 3 consecutive cycles at 0x100,0x104,0x108, done_o 3 cycles after start.
- len=0: start -> no mem_we_o, done_o high exactly one cycle after start edge, count_o=0.
- Abort: fill len=10, abort_i at 4th write cycle -> exactly 4 writes, no done_o, busy_o=0 next cycle; start while busy ignored (second start during copy produces no extra writes).
- Wrap: copy dst=0xFFFFFFFC len=2 -> writes at 0xFFFFFFFC then 0x00000000.
